jtcop_sndlatch: RTL and testbench

Main-CPU side of the sound command path. It is the transmitter that produces the `latch[7:0]` byte and the `snreq` interrupt consumed by the HuC6280 sound subsystem.
- Main CPU writes command bytes; they are queued in a small FIFO.
- The head byte is presented on `latch`, and `snreq` is raised until the sound CPU reads the latch.
- It sits in the game top level, between the main CPU address decoder and jtcop_snd.

---
 rtl/jtcop_snd_pkg.sv | 5 +
 rtl/jtcop_sndlatch_fifo.sv | 61 ++++++
 rtl/jtcop_sndlatch.sv | 58 +++++
 tb/tb_jtcop_sndlatch.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/jtcop_snd_pkg.sv
// rtl/jtcop_snd_pkg.sv - shared constants for the sound command path
package jtcop_snd_pkg;
    localparam logic [7:0] LATCH_RST = 8'h00;
    localparam int SND_DEPTH = 4;
endpackage

// File: rtl/jtcop_sndlatch_fifo.sv
// rtl/jtcop_sndlatch_fifo.sv - command byte queue with head look-ahead
module jtcop_sndlatch_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic [7:0] head_nxt,
    output logic       load,
    output logic       go_empty,
    output logic       drop,
    output logic       full,
    output logic       empty
);
    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic        push_ok, pop_ok, single;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign single  = count == (AW+1)'(1);
    // A full queue still accepts a write when the sound CPU pops in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok;
    assign head    = mem[rd_ptr];

    // The head changes when a byte enters an empty queue or a pop leaves data behind.
    assign load     = (push_ok & empty) | (pop_ok & (~single | push_ok));
    assign go_empty = pop_ok & single & ~push_ok;

    always_comb begin
        head_nxt = mem[rd_ptr + AW'(1)];
        if (empty || single) head_nxt = din;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/jtcop_sndlatch.sv
// rtl/jtcop_sndlatch.sv - main CPU to sound CPU command latch with queue
module jtcop_sndlatch
    import jtcop_snd_pkg::*;
#(
    parameter int DEPTH = SND_DEPTH,
    parameter int AW    = 2,
    parameter int PULSE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       main_wr,
    input  logic [7:0] main_din,
    output logic       main_full,
    output logic       main_pending,
    input  logic       snd_rd,
    output logic [7:0] latch,
    output logic       snreq,
    output logic       ovf,
    input  logic       ovf_clr
);
    logic [7:0] head, head_nxt;
    logic       load, go_empty, drop, full, empty;

    jtcop_sndlatch_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (main_wr),
        .pop      (snd_rd),
        .din      (main_din),
        .head     (head),
        .head_nxt (head_nxt),
        .load     (load),
        .go_empty (go_empty),
        .drop     (drop),
        .full     (full),
        .empty    (empty)
    );

    assign main_full    = full;
    assign main_pending = ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch <= LATCH_RST;
            snreq <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (load) latch <= head_nxt;
            if (PULSE != 0) snreq <= load;
            else            snreq <= load | (snreq & ~go_empty);
            if (ovf_clr)   ovf <= 1'b0;
            else if (drop) ovf <= 1'b1;
        end
    end

    logic unused_head;
    assign unused_head = ^head;
endmodule

// File: tb/tb_jtcop_sndlatch.sv
// tb/tb_jtcop_sndlatch.sv - scoreboard bench for jtcop_sndlatch
module tb_jtcop_sndlatch;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr0 = 0, rd0 = 0, clr0 = 0;
    logic [7:0] din0 = 0;
    logic       full0, pend0, snreq0, ovf0;
    logic [7:0] latch0;
    logic       wr1 = 0, rd1 = 0, clr1 = 0;
    logic [7:0] din1 = 0;
    logic       full1, pend1, snreq1, ovf1;
    logic [7:0] latch1;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    jtcop_sndlatch #(.DEPTH(4), .AW(2), .PULSE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .main_wr(wr0), .main_din(din0),
        .main_full(full0), .main_pending(pend0), .snd_rd(rd0),
        .latch(latch0), .snreq(snreq0), .ovf(ovf0), .ovf_clr(clr0)
    );

    jtcop_sndlatch #(.DEPTH(4), .AW(2), .PULSE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .main_wr(wr1), .main_din(din1),
        .main_full(full1), .main_pending(pend1), .snd_rd(rd1),
        .latch(latch1), .snreq(snreq1), .ovf(ovf1), .ovf_clr(clr1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sound CPU side: each read of a pending latch consumes the next expected byte.
    always @(negedge clk) begin
        if (rst_n && rd0 && snreq0) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_underflow: got %0h expected no read", latch0);
            end else begin
                chk("sb_latch", {24'd0, latch0}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    always @(negedge clk) if (rst_n && snreq1) pulses++;

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic cyc0(input bit w, input logic [7:0] d, input bit r, input bit c);
        wr0 = w; din0 = d; rd0 = r; clr0 = c;
        align();
        wr0 = 0; rd0 = 0; clr0 = 0;
    endtask

    task automatic cyc1(input bit w, input logic [7:0] d, input bit r);
        wr1 = w; din1 = d; rd1 = r;
        align();
        wr1 = 0; rd1 = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_latch", latch0, 8'h00);
        chk("rst_snreq", snreq0, 0);
        chk("rst_full", full0, 0);
        chk("rst_pending", pend0, 0);
        chk("rst_ovf", ovf0, 0);
        @(negedge clk) rst_n = 1'b1;
        align(); align();
        chk("rel_snreq", snreq0, 0);

        // single command
        cyc0(1, 8'h3A, 0, 0); exp_q.push_back(8'h3A);
        look();
        chk("t1_latch", latch0, 8'h3A);
        chk("t1_snreq", snreq0, 1);
        chk("t1_pending", pend0, 1);
        repeat (8) align();
        cyc0(0, 0, 1, 0);
        look();
        chk("t1_snreq_drop", snreq0, 0);
        chk("t1_pending_drop", pend0, 0);
        chk("t1_latch_hold", latch0, 8'h3A);
        align();

        // burst to full, then overflow
        for (int i = 1; i <= 4; i++) begin
            cyc0(1, 8'(i), 0, 0);
            exp_q.push_back(8'(i));
        end
        look();
        chk("t2_full", full0, 1);
        chk("t2_ovf_pre", ovf0, 0);
        chk("t2_latch", latch0, 8'h01);
        align();
        cyc0(1, 8'h05, 0, 0);
        look();
        chk("t2_ovf", ovf0, 1);
        chk("t2_full_hold", full0, 1);
        align();
        cyc0(0, 0, 0, 1);
        look();
        chk("t2_ovf_clr", ovf0, 0);
        align();

        // simultaneous write and read while full
        cyc0(1, 8'h55, 1, 0); exp_q.push_back(8'h55);
        look();
        chk("t3_full", full0, 1);
        chk("t3_ovf", ovf0, 0);
        chk("t3_latch", latch0, 8'h02);
        align();
        for (int i = 0; i < 3; i++) begin
            cyc0(0, 0, 1, 0);
            look();
            chk("t3_snreq_held", snreq0, 1);
            align();
        end
        chk("t3_latch55", latch0, 8'h55);
        cyc0(0, 0, 1, 0);
        look();
        chk("t3_snreq_end", snreq0, 0);
        chk("t3_pending_end", pend0, 0);
        align();

        // empty read, overflow clear priority
        cyc0(0, 0, 1, 0);
        look();
        chk("t5_empty_latch", latch0, 8'h55);
        chk("t5_empty_snreq", snreq0, 0);
        chk("t5_empty_pending", pend0, 0);
        align();
        cyc0(1, 8'hAA, 0, 0); exp_q.push_back(8'hAA);
        cyc0(1, 8'hBB, 0, 0); exp_q.push_back(8'hBB);
        cyc0(1, 8'hCC, 0, 0); exp_q.push_back(8'hCC);
        cyc0(1, 8'hDD, 0, 0); exp_q.push_back(8'hDD);
        cyc0(1, 8'hEE, 0, 1);
        look();
        chk("t5_clr_prio", ovf0, 0);
        chk("t5_full", full0, 1);
        align();
        cyc0(1, 8'hEE, 0, 0);
        look();
        chk("t5_ovf_set", ovf0, 1);
        align();

        // pulse mode
        cyc1(1, 8'hA0, 0);
        look();
        chk("t4_latch_a0", latch1, 8'hA0);
        chk("t4_pulse1", snreq1, 1);
        align();
        cyc1(1, 8'hA1, 0);
        look();
        chk("t4_pulse1_end", snreq1, 0);
        chk("t4_latch_hold", latch1, 8'hA0);
        align();
        cyc1(0, 0, 1);
        look();
        chk("t4_latch_a1", latch1, 8'hA1);
        chk("t4_pulse2", snreq1, 1);
        align();
        look();
        chk("t4_pulse2_end", snreq1, 0);
        chk("t4_pulse_count", pulses, 2);
        align();

        // async reset mid-burst
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_latch", latch0, 8'h00);
        chk("t6_snreq", snreq0, 0);
        chk("t6_pending", pend0, 0);
        chk("t6_full", full0, 0);
        chk("t6_ovf", ovf0, 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        align();
        look();
        chk("t6_rel_snreq", snreq0, 0);
        align();
        cyc0(1, 8'h5C, 0, 0); exp_q.push_back(8'h5C);
        look();
        chk("t6_latch_new", latch0, 8'h5C);
        chk("t6_snreq_new", snreq0, 1);
        align();
        cyc0(0, 0, 1, 0);
        look();
        chk("t6_snreq_drop", snreq0, 0);
        align();

        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
